int_sync_crossing_sink_filt: RTL and testbench
==============================================

INT_SYNC_CROSSING_SINK_FILT -- requirements
Module: int_sync_crossing_sink_filt

Interface
REQ-001 Parameter WIDTH, default 2: number of interrupt lines.
REQ-002 Parameter SYNC_STAGES, default 3, range 2..4: synchronizer flop depth.
REQ-003 Parameter FILTER_CYCLES, default 4, range 1..15: consecutive stable cycles required before the filtered level changes.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-006 auto_in_sync  input  WIDTH  interrupt levels from the remote source domain; asynchronous to clock.
REQ-007 auto_out  output  WIDTH  synchronized, filtered interrupt levels; registered.
REQ-008 pend_valid  output  1  high when any pend_vec bit is set.
REQ-009 pend_vec  output  WIDTH  per-line latched rising-edge flags; registered.
REQ-010 pend_ack  input  1  consumer acknowledge; clears the pending bits currently shown.

Function
REQ-011 Each auto_in_sync bit SHALL pass through SYNC_STAGES flops; stage 1 is the only flop sampling the asynchronous input.
REQ-012 Per line, the filter SHALL hold a counter of 0..FILTER_CYCLES-1; the counter clears to 0 on any cycle where the synchronizer output equals auto_out.
REQ-013 When the synchronizer output differs from auto_out and the counter equals FILTER_CYCLES-1, auto_out SHALL take the synchronizer value on that edge and the counter SHALL clear; otherwise, on a mismatch, the counter increments.
REQ-014 Latency for a held input change SHALL be exactly SYNC_STAGES+FILTER_CYCLES rising edges, counted from the first edge that samples the new value.
REQ-015 An input pulse shorter than FILTER_CYCLES synchronized cycles SHALL produce no change on auto_out and no pending bit.
REQ-016 pend_vec[i] SHALL set on the same edge on which auto_out[i] goes 0->1; falling edges SHALL NOT affect pend_vec.
REQ-017 When pend_ack is high, every pend_vec bit that is high on that edge SHALL clear, unless its own set condition is true on the same edge; in that case set wins and the bit stays 1.
REQ-018 pend_ack with pend_valid low SHALL have no effect.
REQ-019 pend_valid SHALL equal the OR of pend_vec; it is combinational from registered state only.
REQ-020 Lines SHALL be fully independent; simultaneous events on different lines SHALL each be handled per REQ-012..REQ-017.

Reset
REQ-021 With reset low at a rising edge, all synchronizer flops, filter counters, auto_out, pend_vec and internal edge state SHALL become 0; pend_valid SHALL be 0.
REQ-022 Reset low mid-count SHALL discard the count in progress; after reset releases, filtering restarts from 0 and a still-high input produces a fresh rise and pending bit after the full latency.
REQ-023 While reset is low, pend_ack SHALL be ignored.

Configuration
REQ-024 Macro INT_SYNC_SINK_FILTER_EN: when defined, the filter counters per REQ-012..REQ-015 SHALL be present.
REQ-025 When INT_SYNC_SINK_FILTER_EN is not defined, the counters SHALL be absent: auto_out SHALL be a register loaded from the last synchronizer stage, latency SHALL be SYNC_STAGES+1 edges, FILTER_CYCLES SHALL be ignored, and REQ-016..REQ-019 SHALL still apply.

Verification (WIDTH=2, SYNC_STAGES=3, FILTER_CYCLES=4, macro defined unless noted)
REQ-026 Hold reset low for 2 cycles with auto_in_sync=2'b11 -> auto_out=0, pend_vec=0, pend_valid=0 throughout.
REQ-027 Release reset, then step auto_in_sync[0] 0->1 and hold -> auto_out[0] rises exactly 7 edges after first sampling; pend_vec=2'b01 and pend_valid=1 on that same edge.
REQ-028 Drive a 3-cycle high glitch on auto_in_sync[1] -> auto_out[1] stays 0 and pend_vec[1] stays 0 for 20 cycles.
REQ-029 With pend_vec=2'b01, assert pend_ack on the edge where auto_out[1] rises -> pend_vec=2'b10 after that edge; with pend_vec[0] already set, assert pend_ack on the edge where auto_out[0] re-rises -> pend_vec[0] stays 1.
REQ-030 Pull reset low 2 edges into a filter count on line 0, release, keep the input high -> auto_out[0] rises 7 edges after release, with exactly one pending set.
REQ-031 With the macro undefined, step auto_in_sync[0] 0->1 -> auto_out[0] rises exactly 4 edges later; a 1-cycle glitch that is captured by stage 1 propagates to auto_out.

Source files
------------

// File: rtl/int_sync_crossing_sink_filt.sv
// int_sync_crossing_sink_filt
// Interrupt sink for a clock-domain crossing. Each line is synchronized through
// SYNC_STAGES flops and, when INT_SYNC_SINK_FILTER_EN is defined, de-glitched by
// a per-line stability counter before reaching auto_out. Rising edges of
// auto_out are latched into pend_vec until the consumer acknowledges them.
//
// Configuration macro: INT_SYNC_SINK_FILTER_EN
//   defined   : auto_out changes only after FILTER_CYCLES consecutive cycles of
//               disagreement with the synchronizer output
//               (latency SYNC_STAGES+FILTER_CYCLES edges).
//   undefined : auto_out is a plain register behind the last synchronizer stage
//               (latency SYNC_STAGES+1 edges); FILTER_CYCLES is only range-checked.
//
// Handshake: pend_valid is high whenever any pend_vec bit is set. A cycle with
// pend_ack high at the rising edge consumes every bit shown in pend_vec on that
// edge; a bit whose rising edge lands on the same clock stays set. pend_ack
// with pend_valid low is harmless.

module int_sync_crossing_sink_filt #(
  parameter int WIDTH         = 2,
  parameter int SYNC_STAGES   = 3,
  parameter int FILTER_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] auto_in_sync,
  output logic [WIDTH-1:0] auto_out,
  output logic             pend_valid,
  output logic [WIDTH-1:0] pend_vec,
  input  logic             pend_ack
);

  // Elaboration-time parameter range checks
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be in 2..4");
  end
  if (FILTER_CYCLES < 1 || FILTER_CYCLES > 15) begin : g_bad_filter_cycles
    $error("FILTER_CYCLES must be in 1..15");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("WIDTH must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Synchronizer: stage 0 is the only flop that sees the asynchronous input.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Shift the interrupt levels through the synchronizer chain
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= auto_in_sync;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Level filter: out_d is the value auto_out takes on the next edge.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] out_d;

`ifdef INT_SYNC_SINK_FILTER_EN
  // Counter just wide enough for 0..FILTER_CYCLES-1 (at least one bit).
  localparam int              CNT_W    = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Per line: count consecutive disagreements; flip auto_out on the last one
  always_comb begin
    out_d = auto_out;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_out[i] != auto_out[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          out_d[i] = sync_out[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Filter counter registers; reset discards any count in progress
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  // Unfiltered: auto_out simply registers the last synchronizer stage
  always_comb begin
    out_d = sync_out;
  end
`endif

  // ---------------------------------------------------------------------------
  // Output level and pending flags.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] pend_d;

  // A rise is detected against the registered auto_out, so it lands on the
  // same edge that drives auto_out high. Set beats acknowledge.
  always_comb begin
    rise   = out_d & ~auto_out;
    pend_d = pend_vec | rise;
    if (pend_ack) begin
      pend_d = rise;
    end
  end

  // Registered filtered level and pending vector; reset overrides pend_ack
  always_ff @(posedge clock) begin
    if (!reset) begin
      auto_out <= '0;
      pend_vec <= '0;
    end else begin
      auto_out <= out_d;
      pend_vec <= pend_d;
    end
  end

  assign pend_valid = |pend_vec;

endmodule

// File: tb/tb_int_sync_crossing_sink_filt.sv
// Bench for int_sync_crossing_sink_filt (WIDTH=2, SYNC_STAGES=3, FILTER_CYCLES=4).
// Follows INT_SYNC_SINK_FILTER_EN the same way as the design.

module tb_int_sync_crossing_sink_filt;

  localparam int W = 2;
  localparam int S = 3;
  localparam int F = 4;
`ifdef INT_SYNC_SINK_FILTER_EN
  localparam int LAT  = S + F;
  localparam bit FILT = 1'b1;
`else
  localparam int LAT  = S + 1;
  localparam bit FILT = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         pend_ack = 1'b0;
  logic [W-1:0] auto_in_sync = '0;
  logic [W-1:0] auto_out;
  logic [W-1:0] pend_vec;
  logic         pend_valid;

  always #5 clock = ~clock;

  int_sync_crossing_sink_filt #(
    .WIDTH(W),
    .SYNC_STAGES(S),
    .FILTER_CYCLES(F)
  ) dut (
    .clock(clock),
    .reset(reset),
    .auto_in_sync(auto_in_sync),
    .auto_out(auto_out),
    .pend_valid(pend_valid),
    .pend_vec(pend_vec),
    .pend_ack(pend_ack)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: history of sampled input words (index 0 = newest edge).
  // The synchronizer output seen at edge k is the word sampled S edges earlier,
  // i.e. hist[S]. Filtered: a line flips when the last F such values all
  // disagree with the current output.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_out  = '0;
  logic [W-1:0] m_pend = '0;

  typedef struct {
    logic         rst;
    logic [W-1:0] in_v;
    logic         ack;
    logic [W-1:0] exp_out;
    logic [W-1:0] exp_pend;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    hist.delete();
    for (int k = 0; k < S + F; k++) hist.push_back('0);
    m_out  = '0;
    m_pend = '0;
  endfunction

  function automatic void model_edge(input logic r, input logic [W-1:0] in_v, input logic a);
    logic [W-1:0] nxt;
    logic [W-1:0] rs;
    if (!r) begin
      model_clear();
      return;
    end
    hist.push_front(in_v);
    while (hist.size() > S + F) void'(hist.pop_back());
    nxt = m_out;
    if (FILT) begin
      for (int i = 0; i < W; i++) begin
        bit flip;
        flip = 1'b1;
        for (int j = 0; j < F; j++) begin
          if (hist[S+j][i] == m_out[i]) flip = 1'b0;
        end
        if (flip) nxt[i] = ~m_out[i];
      end
    end else begin
      nxt = hist[S];
    end
    rs     = nxt & ~m_out;
    m_pend = a ? rs : (m_pend | rs);
    m_out  = nxt;
  endfunction

  // ---------------- driver ----------------
  // Drive at the falling edge, let one rising edge happen, compare at the next
  // falling edge against the model.
  task automatic step(input logic r, input logic [W-1:0] in_v, input logic a);
    reset        = r;
    auto_in_sync = in_v;
    pend_ack     = a;
    @(posedge clock);
    model_edge(r, in_v, a);
    @(negedge clock);
    check("model_out", auto_out, m_out);
    check("model_pend", pend_vec, m_pend);
    check("model_valid", pend_valid, |m_pend);
  endtask

  task automatic hold(input logic [W-1:0] in_v, input int n);
    for (int k = 0; k < n; k++) step(1'b1, in_v, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    vec_t v;
    int   first;
    int   nhigh;
    int   nsets;
    logic prev_p;
    logic [W-1:0] cur;
    int   hold_cnt [W];

    model_clear();

    // Table: reset with inputs high, release, then a held step on line 0.
    for (int k = 0; k < 2; k++) begin
      v = '{rst: 1'b0, in_v: 2'b11, ack: 1'b0, exp_out: 2'b00, exp_pend: 2'b00};
      vecs.push_back(v);
    end
    for (int k = 0; k < 3; k++) begin
      v = '{rst: 1'b1, in_v: 2'b00, ack: 1'b0, exp_out: 2'b00, exp_pend: 2'b00};
      vecs.push_back(v);
    end
    for (int k = 1; k <= LAT + 2; k++) begin
      v = '{rst: 1'b1, in_v: 2'b01, ack: 1'b0,
            exp_out: (k >= LAT) ? 2'b01 : 2'b00,
            exp_pend: (k >= LAT) ? 2'b01 : 2'b00};
      vecs.push_back(v);
    end

    @(negedge clock);
    foreach (vecs[n]) begin
      step(vecs[n].rst, vecs[n].in_v, vecs[n].ack);
      check("tbl_out", auto_out, vecs[n].exp_out);
      check("tbl_pend", pend_vec, vecs[n].exp_pend);
      check("tbl_valid", pend_valid, |vecs[n].exp_pend);
    end

    // Falling edge leaves pending alone; ack on the re-rise edge keeps bit 0 set.
    hold(2'b00, LAT + 2);
    check("fall_out", auto_out, 2'b00);
    check("fall_keeps_pend", pend_vec, 2'b01);
    hold(2'b01, LAT - 1);
    step(1'b1, 2'b01, 1'b1);
    check("rerise_out", auto_out, 2'b01);
    check("ack_set_wins", pend_vec, 2'b01);

    // Ack on the edge where line 1 rises: bit 0 clears, bit 1 sets.
    hold(2'b11, LAT - 1);
    step(1'b1, 2'b11, 1'b1);
    check("ack_other_out", auto_out, 2'b11);
    check("ack_clear_other", pend_vec, 2'b10);
    step(1'b1, 2'b11, 1'b1);
    check("ack_clear_all", pend_vec, 2'b00);
    check("ack_clear_valid", pend_valid, 1'b0);

    // Glitch on line 1.
    hold(2'b00, LAT + 2);
    step(1'b1, 2'b00, 1'b1);
    if (FILT) begin
      hold(2'b10, 3);
      for (int k = 0; k < 20; k++) begin
        step(1'b1, 2'b00, 1'b0);
        check("glitch_out1", auto_out[1], 1'b0);
        check("glitch_pend1", pend_vec[1], 1'b0);
      end
    end else begin
      first = 0;
      nhigh = 0;
      step(1'b1, 2'b10, 1'b0);
      if (auto_out[1]) begin
        nhigh++;
        first = 1;
      end
      for (int k = 2; k <= 21; k++) begin
        step(1'b1, 2'b00, 1'b0);
        if (auto_out[1]) begin
          nhigh++;
          if (first == 0) first = k;
        end
      end
      check("glitch_pass_edge", first, LAT);
      check("glitch_pass_width", nhigh, 1);
      check("glitch_pass_pend", pend_vec, 2'b10);
      step(1'b1, 2'b00, 1'b1);
    end

    // Reset in the middle of a filter count on line 0.
    hold(2'b01, FILT ? S + 2 : S - 1);
    check("pre_reset_out", auto_out, 2'b00);
    step(1'b0, 2'b01, 1'b1);
    check("reset_out", auto_out, 2'b00);
    check("reset_pend", pend_vec, 2'b00);
    first  = 0;
    nsets  = 0;
    prev_p = 1'b0;
    for (int k = 1; k <= 3 * LAT; k++) begin
      step(1'b1, 2'b01, 1'b0);
      if (auto_out[0] && first == 0) first = k;
      if (pend_vec[0] && !prev_p) nsets++;
      prev_p = pend_vec[0];
    end
    check("post_reset_rise_edge", first, LAT);
    check("post_reset_pend_sets", nsets, 1);

    // Randomized phase: per-line held levels of random length, random acks,
    // occasional resets.
    cur = '0;
    for (int i = 0; i < W; i++) hold_cnt[i] = 0;
    for (int n = 0; n < 900; n++) begin
      for (int i = 0; i < W; i++) begin
        if (hold_cnt[i] == 0) begin
          cur[i]      = 1'($urandom_range(0, 1));
          hold_cnt[i] = $urandom_range(1, 2 * F + 3);
        end
        hold_cnt[i]--;
      end
      step(($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1, cur,
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
